gpi_link_arbiter: RTL and testbench
===================================

GPI_LINK_ARBITER -- requirements
Module: gpi_link_arbiter

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles GPO is stable before ACK rises (legal 1..255).
REQ-002 SHALL have parameter HIGH_CYC, default 4: cycles ACK is held high (legal 1..255).
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles GPO is held stable after ACK falls (legal 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N has a word to send.
REQ-007 SHALL have ports req0_data and req1_data, input, 23 bits each: the word offered by requester N.
REQ-008 SHALL have ports req0_ready and req1_ready, output, 1 bit each: the word from requester N is accepted this cycle.
REQ-009 SHALL have port GPO, output, 23 bits: the registered data bus to the link receiver's GPI.
REQ-010 SHALL have port ACK, output, 1 bit: the registered strobe; the receiver samples GPO on the falling edge of ACK.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 SHALL have port last_grant, output, 1 bit: index of the most recently accepted requester.

Function
REQ-013 SHALL implement the states IDLE, SETUP, STROBE and HOLD, with a cycle counter of at least 8 bits.
REQ-014 In IDLE, with at least one valid asserted, SHALL grant exactly one requester and assert that requester's ready combinationally in the same cycle.
REQ-015 Arbitration SHALL be round-robin: if both valids are high, grant the requester != last_grant; if one valid is high, grant it.
REQ-016 reqN_ready SHALL be low in every state other than IDLE and for the non-granted requester.
REQ-017 On the edge ending an IDLE grant cycle, SHALL do all of the following: load GPO with the granted data, update last_grant, enter SETUP and clear the counter.
REQ-018 SETUP SHALL last SETUP_CYC cycles with ACK=0, then enter STROBE with ACK=1.
REQ-019 STROBE SHALL last HIGH_CYC cycles with ACK=1, then enter HOLD with ACK=0; this transition is the only ACK falling edge.
REQ-020 HOLD SHALL last HOLD_CYC cycles with ACK=0, then return to IDLE.
REQ-021 GPO SHALL remain constant from the load edge until the next accepted word, including while in IDLE.
REQ-022 The transfer period SHALL be 1+SETUP_CYC+HIGH_CYC+HOLD_CYC cycles, which is 9 with the defaults; back-to-back grants SHALL be possible on the first IDLE cycle after HOLD.
REQ-023 ACK SHALL be driven from a flop only and SHALL be glitch-free.
REQ-024 A valid that deasserts before it is granted SHALL be dropped with no side effect; a valid that changes while busy SHALL be ignored.
REQ-025 With both valids continuously high, grants SHALL strictly alternate 0,1,0,1.

Reset
REQ-026 While reset is high, the block SHALL hold the state at IDLE and the counter at 0.
REQ-027 While reset is high, the block SHALL hold GPO=23'h0, ACK=0, busy=0, last_grant=1 (so requester 0 wins first) and both readys at 0.
REQ-028 Reset asserted mid-transfer SHALL force ACK low asynchronously and abort the word without retry.
REQ-029 Because the link receiver shares reset and clears on it, any ACK fall caused by reset SHALL be harmless.
REQ-030 After reset is released, the first grant SHALL be possible on the first rising clk edge.

Verification
REQ-031 Single transfer (defaults): req0_valid=1 and req0_data=23'h12345 for one cycle at T0 -> req0_ready=1 at T0; GPO=23'h12345 from T0+1; ACK high T0+3..T0+6, falls at the T0+7 edge; busy low at T0+9.
REQ-032 Contention: both valids held high with data 23'h000AAA and 23'h055555 -> GPO sequence 000AAA, 055555, 000AAA with grants 9 cycles apart and last_grant toggling.
REQ-033 Dropped request: req1_valid pulsed for one cycle while busy -> no req1_ready, GPO unchanged, no extra ACK pulse.
REQ-034 Reset mid-STROBE: reset asserted at T0+4 -> ACK=0 and GPO=0 immediately; after release, req0 wins if both requesters are valid.
REQ-035 Parameters SETUP_CYC=1, HIGH_CYC=1, HOLD_CYC=1 -> a 4-cycle period with a 1-cycle ACK pulse; the receiver model captures every word in order.
REQ-036 A bench assertion SHALL check that GPO never changes from ACK rise through HOLD_CYC cycles after ACK falls.

Source files
------------

// File: rtl/gpi_link_arbiter.sv
// Two-requester round-robin arbiter driving a strobed GPO/ACK link.
// Each accepted word is held on GPO for a setup phase, an ACK-high phase
// and a hold phase; the receiver captures GPO on the falling edge of ACK.
module gpi_link_arbiter #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HIGH_CYC  = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [22:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [22:0] req1_data,
  output logic        req1_ready,
  output logic [22:0] GPO,
  output logic        ACK,
  output logic        busy,
  output logic        last_grant
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HIGH_LAST  = 8'(HIGH_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       grant;
  logic       any_valid;

  assign any_valid = req0_valid | req1_valid;

  // Round-robin pick: on contention the requester not served last wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readys are only offered while idle; reset is folded in because the
  // state register sits at IDLE throughout reset.
  assign req0_ready = ~reset & (state == IDLE) & req0_valid & ~grant;
  assign req1_ready = ~reset & (state == IDLE) & req1_valid &  grant;
  assign busy       = (state != IDLE);

  // Transfer sequencer: load word, setup, strobe ACK, hold, back to idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      GPO        <= '0;
      ACK        <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            GPO        <= grant ? req1_data : req0_data;
            last_grant <= grant;
            state      <= SETUP;
            cnt        <= '0;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= STROBE;
            ACK   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STROBE: begin
          if (cnt == HIGH_LAST) begin
            state <= HOLD;
            ACK   <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          ACK   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpi_link_arbiter.sv
// Scoreboard bench for gpi_link_arbiter: a default-parameter instance and
// a 1/1/1 instance. Stimulus pushes expected words; receiver-model monitors
// pop and compare on every ACK falling edge.
module tb_gpi_link_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // default instance
  logic        req0_valid, req1_valid;
  logic [22:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [22:0] gpo;
  logic        ack, busy, last_grant;

  // fast instance
  logic        f_req0_valid, f_req1_valid;
  logic [22:0] f_req0_data, f_req1_data;
  logic        f_req0_ready, f_req1_ready;
  logic [22:0] f_gpo;
  logic        f_ack, f_busy, f_last_grant;

  logic [22:0] exp_q[$];
  logic [22:0] f_exp_q[$];
  int          ack_falls = 0;
  int          f_ack_falls = 0;

  gpi_link_arbiter dut (
    .clk(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .GPO(gpo), .ACK(ack), .busy(busy), .last_grant(last_grant)
  );

  gpi_link_arbiter #(.SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .reset(rst),
    .req0_valid(f_req0_valid), .req0_data(f_req0_data), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_data(f_req1_data), .req1_ready(f_req1_ready),
    .GPO(f_gpo), .ACK(f_ack), .busy(f_busy), .last_grant(f_last_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Receiver model + GPO stability window for the default instance
  bit          prev_ack;
  int          hi_len;
  bit          win;
  logic [22:0] win_gpo;
  int          hold_n;
  logic [22:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
      hi_len   = 0;
      win      = 1'b0;
    end else begin
      if (ack && !prev_ack) begin
        win     = 1'b1;
        win_gpo = gpo;
        hold_n  = 0;
      end
      if (win) begin
        checks++;
        assert (gpo === win_gpo) else begin
          errors++;
          $display("FAIL gpo_stable: got %0h expected %0h (t=%0t)", gpo, win_gpo, $time);
        end
        if (!ack) begin
          hold_n++;
          if (hold_n == 2) win = 1'b0;
        end
      end
      if (ack) hi_len++;
      if (!ack && prev_ack) begin
        chk("ack_width", 32'(hi_len), 32'd4);
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(gpo), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("rx_word", 32'(gpo), 32'(e));
        end
        ack_falls++;
        hi_len = 0;
      end
      prev_ack = ack;
    end
  end

  // Receiver model for the 1/1/1 instance
  bit          f_prev_ack;
  int          f_hi_len;
  logic [22:0] fe;
  always @(negedge clk) begin
    if (rst) begin
      f_prev_ack = 1'b0;
      f_hi_len   = 0;
    end else begin
      if (f_ack) f_hi_len++;
      if (!f_ack && f_prev_ack) begin
        chk("f_ack_width", 32'(f_hi_len), 32'd1);
        if (f_exp_q.size() == 0) begin
          chk("f_unexpected_word", 32'(f_gpo), 32'hFFFF_FFFF);
        end else begin
          fe = f_exp_q.pop_front();
          chk("f_rx_word", 32'(f_gpo), 32'(fe));
        end
        f_ack_falls++;
        f_hi_len = 0;
      end
      f_prev_ack = f_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [22:0] fwords[4];
  int          last_g;
  int          n;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 23'h1; req1_data = 23'h2;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    f_req0_data = '0; f_req1_data = '0;

    // reset state, with both valids asserted
    repeat (2) @(negedge clk);
    chk("rst_gpo", 32'(gpo), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    // single transfer, requester 0
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 23'h12345;
    exp_q.push_back(23'h12345);
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("t1_gpo_%0d", k), 32'(gpo), 32'h12345);
      chk($sformatf("t1_ack_%0d", k), 32'(ack), 32'((k >= 3 && k <= 6) ? 1 : 0));
      chk($sformatf("t1_busy_%0d", k), 32'(busy), 32'((k <= 8) ? 1 : 0));
    end
    chk("t1_last_grant", 32'(last_grant), 32'd0);

    // requester 1 transfer with a dropped pulse on req1 while busy
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 23'h7ABCD;
    exp_q.push_back(23'h7ABCD);
    @(negedge clk);
    chk("d_ready1", 32'(req1_ready), 32'd1);
    chk("d_ready0", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 23'h11111;
    @(negedge clk);
    chk("d_busy_ready1", 32'(req1_ready), 32'd0);
    chk("d_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d_idle", 32'(busy), 32'd0);
    chk("d_gpo", 32'(gpo), 32'h7ABCD);
    chk("d_last_grant", 32'(last_grant), 32'd1);
    chk("d_ack_falls", 32'(ack_falls), 32'd2);
    chk("d_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset during STROBE, then contention from the release
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 23'h3C3C3;
    exp_q.push_back(23'h3C3C3);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_gpo", 32'(gpo), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last_grant", 32'(last_grant), 32'd1);
    exp_q.delete();
    req0_valid = 1'b1; req0_data = 23'h000AAA;
    req1_valid = 1'b1; req1_data = 23'h055555;
    @(negedge clk);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(23'h000AAA);
    exp_q.push_back(23'h055555);
    exp_q.push_back(23'h000AAA);
    for (int off = 0; off <= 18; off++) begin
      @(negedge clk);
      chk($sformatf("c_ready0_%0d", off), 32'(req0_ready), 32'((off == 0 || off == 18) ? 1 : 0));
      chk($sformatf("c_ready1_%0d", off), 32'(req1_ready), 32'((off == 9) ? 1 : 0));
      if (off == 1) chk("c_last_grant_1", 32'(last_grant), 32'd0);
      if (off == 10) chk("c_last_grant_10", 32'(last_grant), 32'd1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("c_last_grant_19", 32'(last_grant), 32'd0);
    chk("c_gpo_19", 32'(gpo), 32'h000AAA);
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_idle", 32'(busy), 32'd0);
    chk("c_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("c_ack_falls", 32'(ack_falls), 32'd5);

    // 1/1/1 instance: back-to-back words every 4 cycles
    fwords[0] = 23'h000001; fwords[1] = 23'h2AAAAA;
    fwords[2] = 23'h555555; fwords[3] = 23'h7FFFFF;
    last_g = 0;
    @(posedge clk); #1;
    f_req0_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_req0_data = fwords[i];
      n = 0;
      @(negedge clk);
      while (!f_req0_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("f_grant_%0d", i), 32'(f_req0_ready), 32'd1);
      if (i > 0) chk($sformatf("f_period_%0d", i), 32'(cyc - last_g), 32'd4);
      last_g = cyc;
      f_exp_q.push_back(fwords[i]);
      @(posedge clk); #1;
    end
    f_req0_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (f_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("f_idle", 32'(f_busy), 32'd0);
    chk("f_queue_empty", 32'(f_exp_q.size()), 32'd0);
    chk("f_ack_falls", 32'(f_ack_falls), 32'd4);
    chk("f_gpo_final", 32'(f_gpo), 32'h7FFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
